disp_hex_mux_n: RTL and testbench

Parametrised N-digit multiplexed seven-segment driver, successor to the fixed 4-digit hex mux. It scans DIGITS common-anode digits in a time-multiplexed fashion, decodes 4-bit hex per digit to active-low segments, and adds three features: tear-free frame-synchronous loading, leading-zero blanking and optional PWM brightness. It sits between the display-value logic (timer/score) and the board's `an`/`sseg` pins.

---
 rtl/disp_pkg.sv | 21 ++
 rtl/hex_to_sseg.sv | 12 +
 rtl/disp_hex_mux_n.sv | 152 +++++++++++++++
 tb/tb_disp_hex_mux_n.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment LUT,
// blank pattern and the frame record held in the shadow/active registers.
package disp_pkg;

  localparam int DISP_MAX_DIGITS = 8;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic [4*DISP_MAX_DIGITS-1:0] hex;
    logic [DISP_MAX_DIGITS-1:0]   dp;
    logic                         blank_lz;
  } disp_frame_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex + decimal point to active-low {dp,g..a} decoder.
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_dp,
  output logic [7:0] o_sseg
);

  assign o_sseg = {~i_dp, SEG_LUT[i_hex]};

endmodule

// File: rtl/disp_hex_mux_n.sv
// N-digit time-multiplexed seven-segment driver with frame-synchronous loading,
// leading-zero blanking and optional PWM dimming (SSEG_BRIGHTNESS_EN).
module disp_hex_mux_n
  import disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SLOT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   hex,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int              CNT_W    = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > DISP_MAX_DIGITS) begin : g_bad_digits
    $error("disp_hex_mux_n: DIGITS must be in 1..%0d", DISP_MAX_DIGITS);
  end
  if (SLOT_CYCLES < 16 || (SLOT_CYCLES % 16) != 0) begin : g_bad_slot
    $error("disp_hex_mux_n: SLOT_CYCLES must be >= 16 and a multiple of 16");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  disp_frame_t      r_shadow;
  disp_frame_t      r_active;
  disp_frame_t      w_in;
  logic             r_pending;
  logic             r_tick;
  logic [DIGITS-1:0] r_an;
  logic [7:0]       r_sseg;

  logic             w_slot_end;
  logic             w_frame_end;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  always_comb begin
    w_in                   = '0;
    w_in.hex[DIGITS*4-1:0] = hex;
    w_in.dp[DIGITS-1:0]    = dp_in;
    w_in.blank_lz          = blank_lz;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow so it is
  // never left pending for a whole extra frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (load) r_shadow <= w_in;
      if (w_frame_end && (load || r_pending)) begin
        r_active  <= load ? w_in : r_shadow;
        r_pending <= 1'b0;
        r_tick    <= 1'b1;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  logic [3:0] w_dig [DISP_MAX_DIGITS];
  logic [3:0] w_v;
  logic       w_dp;
  logic       w_nz;
  logic       w_blank;
  logic       w_gate;
  logic       w_lit;
  logic [7:0] w_seg;
  logic [DIGITS-1:0] w_an_nx;

  always_comb begin
    for (int i = 0; i < DISP_MAX_DIGITS; i++) w_dig[i] = r_active.hex[4*i +: 4];
    w_v  = w_dig[r_idx];
    w_dp = r_active.dp[r_idx];
    w_nz = 1'b0;
    for (int j = 0; j < DISP_MAX_DIGITS; j++) begin
      if (j < DIGITS && j >= int'(r_idx) && w_dig[j] != 4'd0) w_nz = 1'b1;
    end
    w_blank = r_active.blank_lz && (r_idx != 3'd0) && !w_nz;
  end

`ifdef SSEG_BRIGHTNESS_EN
  localparam int PH_DIV = SLOT_CYCLES / 16;
  logic [3:0] w_phase;
  assign w_phase = 4'(r_cnt / CNT_W'(PH_DIV));
  assign w_gate  = (w_phase <= bright);
`else
  logic w_unused_bright;
  assign w_unused_bright = ^bright;
  assign w_gate          = 1'b1;
`endif

  assign w_lit = !w_blank && w_gate;

  hex_to_sseg u_dec (
    .i_hex  (w_v),
    .i_dp   (w_dp),
    .o_sseg (w_seg)
  );

  always_comb begin
    w_an_nx = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_lit && i == int'(r_idx)) w_an_nx[i] = 1'b0;
    end
  end

  // Output stage: an/sseg lag (idx, cnt) by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an   <= '1;
      r_sseg <= SEG_BLANK;
    end else begin
      r_an   <= w_an_nx;
      r_sseg <= w_lit ? w_seg : SEG_BLANK;
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign pending    = r_pending;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Randomised bench for disp_hex_mux_n (DIGITS=4, SLOT_CYCLES=16) against a
// cycle-count based reference model.
module tb_disp_hex_mux_n;

  logic        clk;
  logic        reset;
  logic [15:0] hex;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        pending;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  disp_hex_mux_n #(.DIGITS(4), .SLOT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .hex        (hex),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .bright     (bright),
    .an         (an),
    .sseg       (sseg),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: n counts clock edges since reset release; the shown
  // digit and slot phase follow directly from n.
  logic [6:0]  tb_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          n;
  logic [15:0] m_act_hex, m_sh_hex;
  logic [3:0]  m_act_dp, m_sh_dp;
  logic        m_act_blz, m_sh_blz;
  logic        m_pend, m_tick;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;

  task automatic model_clear();
    n = 0;
    m_act_hex = '0; m_sh_hex = '0; m_act_dp = '0; m_sh_dp = '0;
    m_act_blz = 1'b0; m_sh_blz = 1'b0; m_pend = 1'b0; m_tick = 1'b0;
  endtask

  task automatic step();
    int pos, d, c;
    bit gate, blk;
    @(posedge clk);
    pos  = n % 64;
    d    = pos / 16;
    c    = pos % 16;
    gate = 1'b1;
`ifdef SSEG_BRIGHTNESS_EN
    gate = (c <= int'(bright));
`endif
    blk = m_act_blz && d != 0 && ((m_act_hex >> (4 * d)) == 16'd0);
    if (blk || !gate) begin
      exp_an = 4'hF; exp_sseg = 8'hFF;
    end else begin
      exp_an   = ~(4'b0001 << d);
      exp_sseg = {~m_act_dp[d], tb_lut[m_act_hex[4*d +: 4]]};
    end
    m_tick = 1'b0;
    if (pos == 63 && (load || m_pend)) begin
      if (load) begin
        m_act_hex = hex; m_act_dp = dp_in; m_act_blz = blank_lz;
      end else begin
        m_act_hex = m_sh_hex; m_act_dp = m_sh_dp; m_act_blz = m_sh_blz;
      end
      m_pend = 1'b0; m_tick = 1'b1;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin
      m_sh_hex = hex; m_sh_dp = dp_in; m_sh_blz = blank_lz;
    end
    n++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hex = '0; dp_in = '0; blank_lz = 1'b0; load = 1'b0; bright = 4'hF;
    model_clear();
    #2;
    checks += 4;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
    if (sseg !== 8'hFF) begin errors++; $display("FAIL reset_sseg: got %h want ff", sseg); end
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    checks += 2;
    if (an !== 4'b1110) begin errors++; $display("FAIL reset_first_an: got %b want 1110", an); end
    if (sseg !== 8'hC0) begin errors++; $display("FAIL reset_first_sseg: got %h want c0", sseg); end
  endtask

  task automatic test_load();
    int tick_edge;
    tick_edge = -1;
    hex = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 140; k++) begin
      step();
      if (frame_tick === 1'b1 && tick_edge < 0) tick_edge = n;
      checks += 4;
      if (an !== exp_an) begin errors++; $display("FAIL load_an n=%0d: got %b want %b", n, an, exp_an); end
      if (sseg !== exp_sseg) begin errors++; $display("FAIL load_sseg n=%0d: got %h want %h", n, sseg, exp_sseg); end
      if (pending !== m_pend) begin errors++; $display("FAIL load_pending n=%0d: got %b want %b", n, pending, m_pend); end
      if (frame_tick !== m_tick) begin errors++; $display("FAIL load_tick n=%0d: got %b want %b", n, frame_tick, m_tick); end
    end
    checks++;
    if (tick_edge != 64) begin errors++; $display("FAIL load_tick_cycle: got %0d want 64", tick_edge); end
  endtask

  task automatic test_blanking();
    logic [15:0] pats [5];
    pats[0] = 16'h0070; pats[1] = 16'h0000;
    for (int p = 2; p < 5; p++) begin
      for (int d = 0; d < 4; d++) pats[p][4*d +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
    end
    for (int p = 0; p < 5; p++) begin
      hex = pats[p]; dp_in = 4'($urandom); blank_lz = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 130; k++) begin
        step();
        checks += 4;
        if (an !== exp_an) begin errors++; $display("FAIL blank_an n=%0d: got %b want %b", n, an, exp_an); end
        if (sseg !== exp_sseg) begin errors++; $display("FAIL blank_sseg n=%0d: got %h want %h", n, sseg, exp_sseg); end
        if (pending !== m_pend) begin errors++; $display("FAIL blank_pending n=%0d: got %b want %b", n, pending, m_pend); end
        if (frame_tick !== m_tick) begin errors++; $display("FAIL blank_tick n=%0d: got %b want %b", n, frame_tick, m_tick); end
      end
    end
  endtask

  task automatic test_tear_free();
    while (n % 64 != 20) step();
    hex = 16'hABCD; dp_in = 4'b0101; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 90; k++) begin
      if (k == 15) begin hex = 16'h5E6F; dp_in = 4'b1010; load = 1'b1; end
      else load = 1'b0;
      step();
      checks += 4;
      if (an !== exp_an) begin errors++; $display("FAIL tear_an n=%0d: got %b want %b", n, an, exp_an); end
      if (sseg !== exp_sseg) begin errors++; $display("FAIL tear_sseg n=%0d: got %h want %h", n, sseg, exp_sseg); end
      if (pending !== m_pend) begin errors++; $display("FAIL tear_pending n=%0d: got %b want %b", n, pending, m_pend); end
      if (frame_tick !== m_tick) begin errors++; $display("FAIL tear_tick n=%0d: got %b want %b", n, frame_tick, m_tick); end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back_boundary();
    while (n % 64 != 63) step();
    hex = 16'h9087; dp_in = 4'b0011; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    checks += 2;
    if (pending !== 1'b0) begin errors++; $display("FAIL bypass_pending: got %b want 0", pending); end
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL bypass_tick: got %b want 1", frame_tick); end
    for (int k = 0; k < 40; k++) begin
      step();
      checks += 4;
      if (an !== exp_an) begin errors++; $display("FAIL bypass_an n=%0d: got %b want %b", n, an, exp_an); end
      if (sseg !== exp_sseg) begin errors++; $display("FAIL bypass_sseg n=%0d: got %h want %h", n, sseg, exp_sseg); end
      if (pending !== m_pend) begin errors++; $display("FAIL bypass_pending n=%0d: got %b want %b", n, pending, m_pend); end
      if (frame_tick !== m_tick) begin errors++; $display("FAIL bypass_tick n=%0d: got %b want %b", n, frame_tick, m_tick); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 700; k++) begin
      load = ($urandom_range(0, 19) == 0);
      hex = 16'($urandom); dp_in = 4'($urandom); blank_lz = 1'($urandom);
`ifdef SSEG_BRIGHTNESS_EN
      if (k % 16 == 0) bright = 4'($urandom);
`else
      bright = 4'($urandom);
`endif
      step();
      checks += 4;
      if (an !== exp_an) begin errors++; $display("FAIL rand_an n=%0d: got %b want %b", n, an, exp_an); end
      if (sseg !== exp_sseg) begin errors++; $display("FAIL rand_sseg n=%0d: got %h want %h", n, sseg, exp_sseg); end
      if (pending !== m_pend) begin errors++; $display("FAIL rand_pending n=%0d: got %b want %b", n, pending, m_pend); end
      if (frame_tick !== m_tick) begin errors++; $display("FAIL rand_tick n=%0d: got %b want %b", n, frame_tick, m_tick); end
    end
    load = 1'b0;
    bright = 4'hF;
  endtask

`ifdef SSEG_BRIGHTNESS_EN
  task automatic test_brightness();
    int lit;
    hex = 16'h8888; dp_in = 4'h0; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    while (m_pend || (n % 16) != 0) step();
    bright = 4'd3;
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an !== 4'hF) lit++;
      checks++;
      if (an !== exp_an) begin errors++; $display("FAIL bright_an n=%0d: got %b want %b", n, an, exp_an); end
    end
    checks++;
    if (lit != 4) begin errors++; $display("FAIL bright_duty: got %0d lit cycles want 4", lit); end
    bright = 4'hF;
  endtask
`endif

  task automatic test_async_reset();
    while (n % 16 != 7) step();
    hex = 16'h4321; dp_in = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks += 4;
    if (an !== 4'hF) begin errors++; $display("FAIL areset_an: got %b want 1111", an); end
    if (sseg !== 8'hFF) begin errors++; $display("FAIL areset_sseg: got %h want ff", sseg); end
    if (pending !== 1'b0) begin errors++; $display("FAIL areset_pending: got %b want 0", pending); end
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL areset_tick: got %b want 0", frame_tick); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL areset_hold_an: got %b want 1111", an); end
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 70; k++) begin
      step();
      checks += 4;
      if (an !== exp_an) begin errors++; $display("FAIL arel_an n=%0d: got %b want %b", n, an, exp_an); end
      if (sseg !== exp_sseg) begin errors++; $display("FAIL arel_sseg n=%0d: got %h want %h", n, sseg, exp_sseg); end
      if (pending !== m_pend) begin errors++; $display("FAIL arel_pending n=%0d: got %b want %b", n, pending, m_pend); end
      if (frame_tick !== m_tick) begin errors++; $display("FAIL arel_tick n=%0d: got %b want %b", n, frame_tick, m_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_blanking();
    test_tear_free();
    test_back_to_back_boundary();
`ifdef SSEG_BRIGHTNESS_EN
    test_brightness();
`endif
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
